// File: rtl/micro_seq_if.sv
// Sequencer <-> control-store bundle: microinstruction fields in, micro-PC and STATUS controls out.
// The master drives the microinstruction; the slave is the sequencer.
interface micro_seq_if #(
   parameter int AW    = 12,
   parameter int DEPTH = 4
);
   localparam int SPW = $clog2(DEPTH);

   logic [3:0]     SEQOP;
   logic [AW-1:0]  BADR;
   logic [AW-1:0]  MAPADR;
   logic           COND;
   logic           TERM;
   logic           WAIT;
   logic [AW-1:0]  MPC;
   logic           SHCKL;
   logic [SPW-1:0] SP;
   logic           SERR;

   modport master (
      output SEQOP, BADR, MAPADR, COND, TERM, WAIT,
      input  MPC, SHCKL, SP, SERR
   );

   modport slave (
      input  SEQOP, BADR, MAPADR, COND, TERM, WAIT,
      output MPC, SHCKL, SP, SERR
   );
endinterface

// File: rtl/micro_seq.sv
// Microprogram sequencer: next micro-PC from SEQOP, circular return stack, COND and loop TERM.
// MPC updates one edge after the microinstruction is presented; WAIT freezes all state.
module micro_seq #(
   parameter int AW    = 12,
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   micro_seq_if.slave bus
);
   localparam int SPW = $clog2(DEPTH);

   localparam logic [3:0] OP_JUMP   = 4'd1;
   localparam logic [3:0] OP_JCOND  = 4'd2;
   localparam logic [3:0] OP_JNCOND = 4'd3;
   localparam logic [3:0] OP_CALL   = 4'd4;
   localparam logic [3:0] OP_RET    = 4'd5;
   localparam logic [3:0] OP_LOOP   = 4'd6;
   localparam logic [3:0] OP_MAP    = 4'd7;

   localparam logic [SPW:0] OCC_FULL = (SPW+1)'(DEPTH);

   logic [AW-1:0]  stack_q [DEPTH];
   logic [AW-1:0]  mpc_q, mpc_d, inc;
   logic [SPW-1:0] sp_q, sp_d, pop_adr;
   logic [SPW:0]   occ_q, occ_d;
   logic           serr_q, serr_d;
   logic           push;

   always_comb begin
      inc     = mpc_q + AW'(1);
      pop_adr = sp_q - SPW'(1);
      mpc_d   = inc;
      sp_d    = sp_q;
      occ_d   = occ_q;
      serr_d  = serr_q;
      push    = 1'b0;
      case (bus.SEQOP)
         OP_JUMP:   mpc_d = bus.BADR;
         OP_JCOND:  mpc_d = bus.COND ? bus.BADR : inc;
         OP_JNCOND: mpc_d = bus.COND ? inc : bus.BADR;
         OP_CALL: begin
            push  = 1'b1;
            mpc_d = bus.BADR;
            sp_d  = sp_q + SPW'(1);
            if (occ_q != OCC_FULL)
               occ_d = occ_q + (SPW+1)'(1);
         end
         OP_RET: begin
            // Underflow jumps to the reset vector and leaves the pointer alone.
            if (occ_q == '0) begin
               mpc_d  = '0;
               serr_d = 1'b1;
            end else begin
               mpc_d = stack_q[pop_adr];
               sp_d  = pop_adr;
               occ_d = occ_q - (SPW+1)'(1);
            end
         end
         OP_LOOP:   mpc_d = bus.TERM ? inc : mpc_q;
         OP_MAP:    mpc_d = bus.MAPADR;
         default:   mpc_d = inc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mpc_q  <= '0;
         sp_q   <= '0;
         occ_q  <= '0;
         serr_q <= 1'b0;
      end else if (!bus.WAIT) begin
         mpc_q  <= mpc_d;
         sp_q   <= sp_d;
         occ_q  <= occ_d;
         serr_q <= serr_d;
      end
   end

   // Stack contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (push && !bus.WAIT)
         stack_q[sp_q] <= inc;
   end

   assign bus.MPC   = mpc_q;
   assign bus.SP    = sp_q;
   assign bus.SERR  = serr_q;
   // STATUS samples this on the same edge, so it must drop with rst without waiting for a clock.
   assign bus.SHCKL = (bus.SEQOP == OP_LOOP) & ~bus.TERM & ~bus.WAIT & ~rst;
endmodule

// File: tb/tb_micro_seq.sv
// Directed bench for micro_seq: expected micro-PCs queued at drive time, popped after each edge.
module tb_micro_seq;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [11:0] exp_q [$];

   micro_seq_if #(.AW(12), .DEPTH(4)) bus ();

   micro_seq #(.AW(12), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one microinstruction at the falling edge, check SHCKL combinationally,
   // then compare the registered MPC just after the rising edge.
   task automatic step(input string tag, input logic [3:0] op, input logic [11:0] badr,
                       input logic c, input logic t, input logic w,
                       input logic exp_sh, input logic [11:0] exp_mpc);
      logic [11:0] e;
      bus.SEQOP = op;
      bus.BADR  = badr;
      bus.COND  = c;
      bus.TERM  = t;
      bus.WAIT  = w;
      #1;
      chk({tag, ".shckl"}, 32'(bus.SHCKL), 32'(exp_sh));
      exp_q.push_back(exp_mpc);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({tag, ".mpc"}, 32'(bus.MPC), 32'(e));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      bus.SEQOP  = 4'd0;
      bus.BADR   = '0;
      bus.MAPADR = '0;
      bus.COND   = 1'b0;
      bus.TERM   = 1'b0;
      bus.WAIT   = 1'b0;
      #2;
      chk("rst.mpc",   32'(bus.MPC),   32'h0);
      chk("rst.sp",    32'(bus.SP),    32'h0);
      chk("rst.serr",  32'(bus.SERR),  32'h0);
      chk("rst.shckl", 32'(bus.SHCKL), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Sequential run
      step("cont1", 4'd0, 12'h000, 0, 0, 0, 0, 12'h001);
      step("cont2", 4'd0, 12'h000, 0, 0, 0, 0, 12'h002);
      step("cont3", 4'd0, 12'h000, 0, 0, 0, 0, 12'h003);
      step("cont4", 4'd0, 12'h000, 0, 0, 0, 0, 12'h004);
      chk("cont.serr", 32'(bus.SERR), 32'h0);

      // Conditional branches
      step("jmp010a",  4'd1, 12'h010, 0, 0, 0, 0, 12'h010);
      step("jcond1",   4'd2, 12'h200, 1, 0, 0, 0, 12'h200);
      step("jmp010b",  4'd1, 12'h010, 0, 0, 0, 0, 12'h010);
      step("jcond0",   4'd2, 12'h200, 0, 0, 0, 0, 12'h011);
      step("jmp010c",  4'd1, 12'h010, 0, 0, 0, 0, 12'h010);
      step("jncond1",  4'd3, 12'h200, 1, 0, 0, 0, 12'h011);
      step("jncond0",  4'd3, 12'h200, 0, 0, 0, 0, 12'h200);
      step("reserved", 4'd9, 12'h333, 1, 1, 0, 0, 12'h201);
      step("jmpff",    4'd1, 12'hFFF, 0, 0, 0, 0, 12'hFFF);
      step("wrap",     4'd0, 12'h000, 0, 0, 0, 0, 12'h000);

      // Nested calls with one overflow push (slot 0 overwritten)
      step("jmp100", 4'd1, 12'h100, 0, 0, 0, 0, 12'h100);
      step("call1",  4'd4, 12'h200, 0, 0, 0, 0, 12'h200);
      step("call2",  4'd4, 12'h300, 0, 0, 0, 0, 12'h300);
      step("call3",  4'd4, 12'h400, 0, 0, 0, 0, 12'h400);
      step("call4",  4'd4, 12'h500, 0, 0, 0, 0, 12'h500);
      step("call5",  4'd4, 12'h600, 0, 0, 0, 0, 12'h600);
      chk("call5.sp", 32'(bus.SP), 32'h1);
      step("ret1", 4'd5, 12'h000, 0, 0, 0, 0, 12'h501);
      step("ret2", 4'd5, 12'h000, 0, 0, 0, 0, 12'h401);
      step("ret3", 4'd5, 12'h000, 0, 0, 0, 0, 12'h301);
      step("ret4", 4'd5, 12'h000, 0, 0, 0, 0, 12'h201);
      chk("ret4.serr", 32'(bus.SERR), 32'h0);
      // Occupancy saturated at 4, so the fifth pop is an underflow
      step("ret5", 4'd5, 12'h000, 0, 0, 0, 0, 12'h000);
      chk("ret5.serr", 32'(bus.SERR), 32'h1);
      step("ret6", 4'd5, 12'h000, 0, 0, 0, 0, 12'h000);
      chk("ret6.serr", 32'(bus.SERR), 32'h1);
      chk("ret6.sp",   32'(bus.SP),   32'h1);

      // Loop with TERM
      step("jmp040a", 4'd1, 12'h040, 0, 0, 0, 0, 12'h040);
      for (int i = 0; i < 5; i++)
         step($sformatf("loop%0d", i), 4'd6, 12'h000, 0, 0, 0, 1, 12'h040);
      step("loopterm", 4'd6, 12'h000, 0, 1, 0, 0, 12'h041);
      step("jmp040b",  4'd1, 12'h040, 0, 0, 0, 0, 12'h040);
      step("loopentr", 4'd6, 12'h000, 0, 1, 0, 0, 12'h041);

      // WAIT freezes the loop
      step("jmp040c", 4'd1, 12'h040, 0, 0, 0, 0, 12'h040);
      step("wloop0",  4'd6, 12'h000, 0, 0, 0, 1, 12'h040);
      step("wloop1",  4'd6, 12'h000, 0, 0, 0, 1, 12'h040);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("wait%0d", i), 4'd6, 12'h000, 1, 1, 1, 0, 12'h040);
         chk($sformatf("wait%0d.sp", i), 32'(bus.SP), 32'h1);
      end
      for (int i = 0; i < 3; i++)
         step($sformatf("wloop%0d", i + 2), 4'd6, 12'h000, 0, 0, 0, 1, 12'h040);
      step("wloopterm", 4'd6, 12'h000, 0, 1, 0, 0, 12'h041);

      // WAIT during CALL, then back-to-back CALL/RET
      step("wcall0", 4'd4, 12'h080, 0, 0, 1, 0, 12'h041);
      chk("wcall0.sp", 32'(bus.SP), 32'h1);
      step("wcall1", 4'd4, 12'h080, 0, 0, 1, 0, 12'h041);
      chk("wcall1.sp", 32'(bus.SP), 32'h1);
      step("call080", 4'd4, 12'h080, 0, 0, 0, 0, 12'h080);
      chk("call080.sp", 32'(bus.SP), 32'h2);
      step("ret042", 4'd5, 12'h000, 0, 0, 0, 0, 12'h042);
      chk("ret042.sp", 32'(bus.SP), 32'h1);
      step("call040", 4'd4, 12'h040, 0, 0, 0, 0, 12'h040);
      chk("call040.sp", 32'(bus.SP), 32'h2);

      // Asynchronous reset between edges while looping
      bus.SEQOP = 4'd6;
      bus.TERM  = 1'b0;
      bus.WAIT  = 1'b0;
      #1;
      chk("arst.pre.shckl", 32'(bus.SHCKL), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst.shckl", 32'(bus.SHCKL), 32'h0);
      chk("arst.mpc",   32'(bus.MPC),   32'h0);
      chk("arst.sp",    32'(bus.SP),    32'h0);
      chk("arst.serr",  32'(bus.SERR),  32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.MAPADR = 12'hABC;
      step("map",   4'd7, 12'h000, 0, 0, 0, 0, 12'hABC);
      step("cont5", 4'd0, 12'h000, 0, 0, 0, 0, 12'hABD);
      step("retuf", 4'd5, 12'h000, 0, 0, 0, 0, 12'h000);
      chk("retuf.serr", 32'(bus.SERR), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
